// File: rtl/ur408_pkg.sv
// ---------------------------------------------------------------------------
// ur408_pkg
// Shared definitions for the UR408 fetch front end.
//   INS_W        : instruction word width
//   PC_W_DEFAULT : default word-address width of the PC
//   NOP_INS      : value driven on the instruction bus when nothing is valid
//   fetch_state_e: fetch unit control states (BOOT, RUN)
// ---------------------------------------------------------------------------
package ur408_pkg;

   localparam int INS_W        = 16;
   localparam int PC_W_DEFAULT = 16;

   localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/ifu_pfifo.sv
// ---------------------------------------------------------------------------
// ifu_pfifo
// Small synchronous FIFO with clear and optional empty-bypass.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : drop all stored entries (wins over push)
//   push        : write push_data
//   push_data   : W-bit payload
//   pop         : consume the head (only meaningful when head_valid)
//   head_valid  : head entry available (includes bypassed push when BYPASS)
//   head_data   : head payload
//   count       : number of stored entries (a bypassed entry is not counted)
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module ifu_pfifo #(
   parameter int W      = 32,
   parameter int DEPTH  = 2,
   parameter bit BYPASS = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [W-1:0]               head_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          empty;
   logic          store;
   logic          take;

   assign empty = (count_reg == '0);

   // With bypass, a push into an empty FIFO is visible at the head in the
   // same cycle; if it is also popped it never lands in storage.
   assign head_valid = !empty || (BYPASS && push);
   assign head_data  = (BYPASS && empty) ? push_data : mem[rd_ptr_reg];

   assign store = push && !(BYPASS && empty && pop);
   assign take  = pop && !empty;
   assign count = count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (store) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (take)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + CW'(store) - CW'(take);
      end
   end

   // Storage carries no reset; validity is tracked entirely by count_reg.
   always_ff @(posedge clk) begin
      if (store && !clr) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// UR408 instruction fetch unit: keeps the PC, issues word reads with a
// req/gnt handshake, buffers returned words in a prefetch FIFO and hands
// them to the decoder with a valid/ready handshake. Redirects flush.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req / imem_addr    : fetch request and its word address
//   imem_gnt                : request accepted this cycle
//   imem_rvalid/imem_rdata  : in-order read response
//   ins / ins_pc / ins_valid: FIFO head to the decoder (zero when invalid)
//   ins_ready               : decoder accepts the head
//   redirect / redirect_pc  : flush and restart fetch at redirect_pc
// ---------------------------------------------------------------------------
module ifu_fetch
   import ur408_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INS_W-1:0]  imem_rdata,
   output logic [INS_W-1:0]  ins,
   output logic [PC_W-1:0]   ins_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = INS_W + PC_W;

   fetch_state_e    state_reg, state_next;
   logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [CW-1:0]   discard_reg, discard_next;

   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_next;
   logic [CW-1:0]   fifo_count;
   logic            credit_ok;
   logic            fetch_grant;
   logic            rsp_ok;
   logic            rsp_keep;
   logic            pop;

   logic            shadow_valid;
   logic [PC_W-1:0] shadow_pc;
   logic            head_valid;
   logic [FW-1:0]   head_data;

   // Requests in flight and buffered entries together never exceed DEPTH,
   // so the prefetch FIFO cannot overflow.
   assign credit_ok   = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
   assign fetch_grant = imem_req && imem_gnt;

   // The shadow queue holds exactly the granted-but-unanswered addresses, so
   // its occupancy is the in-flight count and a response with it empty is a
   // protocol error that is simply ignored.
   assign rsp_ok   = imem_rvalid && shadow_valid;
   assign rsp_keep = rsp_ok && (discard_reg == '0) && !redirect;

   assign inflight_next = inflight + CW'(fetch_grant) - CW'(rsp_ok);

   assign ins_valid = head_valid && !redirect;
   assign pop       = ins_valid && ins_ready;
   assign ins       = ins_valid ? head_data[FW-1:PC_W] : NOP_INS;
   assign ins_pc    = ins_valid ? head_data[PC_W-1:0]  : '0;

   always_comb begin
      state_next    = RUN;
      fetch_pc_next = fetch_pc_reg;
      discard_next  = discard_reg;
      imem_req      = 1'b0;
      imem_addr     = '0;

      if (state_reg == RUN) begin
         imem_req  = !redirect && credit_ok;
         imem_addr = fetch_pc_reg;
      end

      if (redirect) begin
         // Everything still outstanding after this cycle belongs to the old
         // stream; a response arriving now is already dropped via rsp_keep.
         fetch_pc_next = redirect_pc;
         discard_next  = inflight_next;
      end else begin
         if (fetch_grant) fetch_pc_next = fetch_pc_reg + PC_W'(1);
         if (rsp_ok && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= BOOT;
         fetch_pc_reg <= RESET_PC;
         discard_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         discard_reg  <= discard_next;
      end
   end

   // Granted addresses, popped in order as responses return.
   ifu_pfifo #(
      .W      (PC_W),
      .DEPTH  (DEPTH),
      .BYPASS (1'b0)
   ) u_shadow (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (1'b0),
      .push       (fetch_grant),
      .push_data  (fetch_pc_reg),
      .pop        (rsp_ok),
      .head_valid (shadow_valid),
      .head_data  (shadow_pc),
      .count      (inflight)
   );

   // Prefetch buffer of {instruction, pc}.
   ifu_pfifo #(
      .W      (FW),
      .DEPTH  (DEPTH),
      .BYPASS (1'b1)
   ) u_pfifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (redirect),
      .push       (rsp_keep),
      .push_data  ({imem_rdata, shadow_pc}),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head_data),
      .count      (fifo_count)
   );

endmodule
